adder_rx: RTL and testbench
===========================

Name: adder_rx

Overview:
Receive-side endpoint for the adder result interface (valid_out / 9-bit sum). The adder has no backpressure, so this block buffers every result in a synchronous FIFO and presents it downstream on a ready/valid handshake. It also produces a stall signal early enough to throttle the operand driver, accounting for the adder's 1-cycle latency. Overflow is flagged rather than silently lost.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >= 4
STALL_MARGIN, 2, free-slot threshold for stall_o; must be >= 2 (adder latency + 1 registered cycle)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  result valid from adder (valid_out)
in_sum  in  9  result data from adder (c)
out_valid  out  1  FIFO head valid
out_sum  out  9  FIFO head data
out_ready  in  1  downstream accepts head
stall_o  out  1  upstream must not assert adder valid_in
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a result was dropped
clr_overflow  in  1  single-cycle clear of overflow

Behaviour:
- Reset: out_valid=0, out_sum=0, count=0, overflow=0, stall_o=0; rd/wr pointers=0; storage contents don't-care.
- Reset mid-operation empties the FIFO immediately. All buffered results are lost. No overflow is recorded.
- Push condition: in_valid && (count < DEPTH || pop).
- Pop condition: out_valid && out_ready.
- Registered FIFO with no fall-through:
  - A push into an empty FIFO gives out_valid=1 the next cycle (latency 1).
  - out_sum = storage[rd_ptr]; it holds stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted because the pop frees the slot.
  - When count==1, the head advances to the new entry on the next cycle; out_valid stays 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Full and not popping, with in_valid=1:
  - The data is dropped.
  - overflow is set the next cycle.
  - count and pointers are unchanged.
- clr_overflow: clears overflow the next cycle. If a new drop occurs in the same cycle, overflow stays 1 (set wins).
- stall_o (registered): 1 when next-state count >= DEPTH-STALL_MARGIN; otherwise 0.
- Guarantee: with STALL_MARGIN=2 and an upstream that honours stall_o on the cycle it is seen, overflow never sets.
- in_sum is taken verbatim (9 bits, no arithmetic). No X-propagation from in_sum occurs when in_valid=0.

Optional Feature:
Macro ADDER_RX_STATS_EN.
- Defined: adds outputs rx_cnt[15:0] (accepted pushes) and drop_cnt[15:0] (dropped results). Both reset to 0, saturate at 16'hFFFF and are cleared by rst_n only.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package adder_pkg:
  - SUM_W=9, OPND_W=8
  - typedef logic [SUM_W-1:0] sum_t
  - DEFAULT_RX_DEPTH=8
- Sub-module adder_rx_fifo: storage array, pointers, count, push/pop logic.
- adder_rx top: push qualification, stall_o, overflow, optional stats.

Test Plan:
- Single result: in_valid=1, in_sum=9'h1FE for one cycle, out_ready=1 -> out_valid=1 with out_sum=9'h1FE exactly 1 cycle later; count returns to 0 after the pop.
- Fill and stall (DEPTH=8, out_ready=0): push 0..7 on consecutive cycles -> stall_o rises once next count=6; count=8; out_sum holds 0.
- Overflow: FIFO full, out_ready=0, push 9'h055 -> overflow=1 the next cycle, count=8. Then drain 8 pops -> sequence 0..7, 9'h055 absent.
- Full with simultaneous push/pop: full, out_ready=1, in_valid=1, in_sum=9'h100 -> count stays 8, overflow=0, 9'h100 emerges as the 8th subsequent output.
- Clear race: clr_overflow=1 in the same cycle as a drop -> overflow remains 1. clr_overflow alone next cycle -> overflow=0.
- Async reset mid-stream: assert rst_n=0 with count=5 -> out_valid=0, count=0, stall_o=0, overflow=0 immediately. After release, the first push gives out_valid 1 cycle later.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared widths and types for the adder datapath and its receive endpoint.
//   SUM_W            : width of an adder result (carry + 8-bit sum)
//   OPND_W           : width of an adder operand
//   DEFAULT_RX_DEPTH : default buffer depth for adder_rx
//   sum_t            : adder result type
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int SUM_W            = 9;
  localparam int OPND_W           = 8;
  localparam int DEFAULT_RX_DEPTH = 8;

  typedef logic [SUM_W-1:0] sum_t;

endpackage : adder_pkg

// File: rtl/adder_rx_fifo.sv
// -----------------------------------------------------------------------------
// adder_rx_fifo
// Synchronous FIFO with a registered head (no fall-through). A push into an
// empty FIFO becomes visible on o_valid/o_data one cycle later.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_push         : write i_data (caller guarantees space or simultaneous pop)
//   i_pop          : consume the head (caller guarantees o_valid)
//   i_data         : result to store
//   o_valid        : head is valid
//   o_data         : head value, stable while not popped
//   o_count        : current occupancy
//   o_count_nxt    : occupancy after this cycle's push/pop
//   o_full         : occupancy equals DEPTH
// -----------------------------------------------------------------------------
module adder_rx_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [SUM_W-1:0]           i_data,
  output logic                       o_valid,
  output logic [SUM_W-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [$clog2(DEPTH):0]     o_count_nxt,
  output logic                       o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sum_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  sum_t          r_head;

  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_rd_ptr_inc;
  sum_t          w_head_nxt;

  // Pointer wraps naturally at DEPTH-1 -> 0 because DEPTH is a power of two.
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next head value: the entry behind the head on a pop, or the incoming
  // result when the FIFO is (or is about to become) otherwise empty.
  always_comb begin
    w_head_nxt = r_head;
    if (i_pop) begin
      if (r_count > CW'(1)) begin
        w_head_nxt = r_mem[w_rd_ptr_inc];
      end else if (i_push) begin
        w_head_nxt = i_data;
      end else begin
        w_head_nxt = r_head;
      end
    end else if (i_push && (r_count == CW'(0))) begin
      w_head_nxt = i_data;
    end else begin
      w_head_nxt = r_head;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
      r_valid  <= 1'b0;
      r_head   <= SUM_W'(0);
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != CW'(0));
      r_head  <= w_head_nxt;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_head;
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;
  assign o_full      = (r_count == CW'(DEPTH));

endmodule : adder_rx_fifo

// File: rtl/adder_rx.sv
// -----------------------------------------------------------------------------
// adder_rx
// Receive endpoint for the adder result interface. Every result is buffered
// (the adder cannot be back-pressured) and presented downstream on a
// ready/valid handshake. stall_o throttles the operand driver early enough to
// cover the adder's 1-cycle latency; dropped results set a sticky overflow.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid      : adder result valid
//   in_sum        : adder result (taken verbatim)
//   out_valid     : head valid
//   out_sum       : head data
//   out_ready     : downstream accepts head
//   stall_o       : upstream must not issue a new adder operation
//   count         : occupancy
//   overflow      : sticky, a result was dropped
//   clr_overflow  : clear overflow (a same-cycle drop wins)
// Optional (macro ADDER_RX_STATS_EN):
//   rx_cnt        : saturating count of accepted results
//   drop_cnt      : saturating count of dropped results
// -----------------------------------------------------------------------------
module adder_rx
  import adder_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_RX_DEPTH,
  parameter int STALL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [SUM_W-1:0]       in_sum,
  output logic                   out_valid,
  output logic [SUM_W-1:0]       out_sum,
  input  logic                   out_ready,
  output logic                   stall_o,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
`ifdef ADDER_RX_STATS_EN
  output logic [15:0]            rx_cnt,
  output logic [15:0]            drop_cnt,
`endif
  input  logic                   clr_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic [CW-1:0] w_count_nxt;
  logic          r_stall;
  logic          r_overflow;

  // A pop frees the slot, so a full FIFO still accepts a simultaneous push.
  assign w_pop  = out_valid && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  adder_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (in_sum),
    .o_valid     (out_valid),
    .o_data      (out_sum),
    .o_count     (count),
    .o_count_nxt (w_count_nxt),
    .o_full      (w_full)
  );

  // Stall from the next occupancy so it lands in the same cycle the count does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= 1'b0;
    end else begin
      r_stall <= (w_count_nxt >= CW'(DEPTH - STALL_MARGIN));
    end
  end

  // Sticky overflow; a drop in the clear cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign stall_o  = r_stall;
  assign overflow = r_overflow;

`ifdef ADDER_RX_STATS_EN
  logic [15:0] r_rx_cnt;
  logic [15:0] r_drop_cnt;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt   <= 16'h0000;
      r_drop_cnt <= 16'h0000;
    end else begin
      if (w_push && (r_rx_cnt != 16'hFFFF))   r_rx_cnt   <= r_rx_cnt + 16'h0001;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'h0001;
    end
  end

  assign rx_cnt   = r_rx_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule : adder_rx

// File: tb/tb_adder_rx.sv
// -----------------------------------------------------------------------------
// tb_adder_rx
// Directed testbench for adder_rx (DEPTH=8, STALL_MARGIN=2).
// -----------------------------------------------------------------------------
module tb_adder_rx;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [8:0] in_sum;
  logic       out_valid;
  logic [8:0] out_sum;
  logic       out_ready;
  logic       stall_o;
  logic [3:0] count;
  logic       overflow;
  logic       clr_overflow;
`ifdef ADDER_RX_STATS_EN
  logic [15:0] rx_cnt;
  logic [15:0] drop_cnt;
`endif

  int n_vec;
  int n_err;

  adder_rx #(
    .DEPTH        (8),
    .STALL_MARGIN (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sum       (in_sum),
    .out_valid    (out_valid),
    .out_sum      (out_sum),
    .out_ready    (out_ready),
    .stall_o      (stall_o),
    .count        (count),
    .overflow     (overflow),
`ifdef ADDER_RX_STATS_EN
    .rx_cnt       (rx_cnt),
    .drop_cnt     (drop_cnt),
`endif
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [8:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sum   = base + 9'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_stall", 32'(stall_o), ((i + 1) >= 6) ? 32'd1 : 32'd0);
      chk("fill_head", 32'(out_sum), 32'(base));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sum = 9'h000;
    out_ready = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    step();

    // Single result, latency 1, popped immediately.
    in_valid = 1'b1; in_sum = 9'h1FE; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_sum", 32'(out_sum), 32'h1FE);
    chk("single_count", 32'(count), 32'd1);
    step();
    chk("single_cnt0", 32'(count), 32'd0);
    chk("single_empty", 32'(out_valid), 32'd0);

    // Fill 0..7, then overflow with 0x055.
    fill(9'h000);
    in_valid = 1'b1; in_sum = 9'h055;
    step();
    in_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_sum", 32'(out_sum), 32'(k));
      step();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_stall", 32'(stall_o), 32'd0);
    out_ready = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("clr_plain", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    fill(9'h010);
    in_valid = 1'b1; in_sum = 9'h100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("pp_sum", 32'(out_sum), (k < 7) ? 32'(9'h011 + 9'(k)) : 32'h100);
      step();
    end
    chk("pp_empty", 32'(count), 32'd0);

    // Clear racing a drop: set wins.
    fill(9'h020);
    in_valid = 1'b1; in_sum = 9'h0AB; clr_overflow = 1'b1;
    step();
    chk("race_ovf", 32'(overflow), 32'd1);
    in_valid = 1'b0;
    step();
    clr_overflow = 1'b0;
    chk("race_clr", 32'(overflow), 32'd0);

    // Set overflow again, pop down to 5, then reset asynchronously.
    in_valid = 1'b1; in_sum = 9'h0CD;
    step();
    in_valid = 1'b0;
    chk("re_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_head", 32'(out_sum), 32'h023);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_sum = 9'h0AA;
    #1;
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_sum", 32'(out_sum), 32'h0AA);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_adder_rx
